pipe_ctrl: RTL
==============

# pipe_ctrl

Pipelined control unit for the 5-stage MIPS core: decodes the ID-stage opcode into a 13-bit control word and carries it through ID/EX, EX/MEM and MEM/WB registers. Detects load-use hazards, produces EX-stage forwarding selects, flushes on jumps and taken branches, and freezes on data-memory wait states. Saturating stall/flush counters support performance measurement. It replaces the purely combinational opcode decoder and sits between the IF/ID register and the datapath stage registers.

## Interface
- OP_W, 6: opcode width
- RA_W, 5: register address width
- CNT_W, 16: width of performance counters
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  IF/ID holds a real instruction
- id_op  in  OP_W  opcode in ID
- id_rs, id_rt, id_rd  in  RA_W each  register fields in ID
- branch_taken  in  1  branch in EX resolved taken (from ALU compare)
- mem_ready  in  1  data memory completes the access this cycle
- id_stall  out  1  hold PC and IF/ID
- if_flush  out  1  zero IF/ID on next edge
- ex_cw, mem_cw, wb_cw  out  13 each  control word per stage
- ex_dst, mem_dst, wb_dst  out  RA_W each  destination register per stage (0 if no regwrite)
- fwd_a, fwd_b  out  2 each  EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
- illegal  out  1  ID holds a valid, unrecognised opcode
- stall_cnt, flush_cnt  out  CNT_W each  saturating counters

## Operation
- Control word bits [12:0]: regdst, alusrc, alu_r, branch, bne, jump, imm_op[2:0] (000 none, 001 addi, 010 andi, 011 ori, 100 slti, 101 lui), memread, memwrite, memtoreg, regwrite.
- Opcodes: R 0x00, j 0x02, beq 0x04, bne 0x05, addi 0x08, slti 0x0A, andi 0x0C, ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B. Unknown or !id_valid decodes to the all-zero bubble; illegal = id_valid & unknown.
- Destination = regdst ? rd : rt, forced to 0 when regwrite=0. Reads rt: R, beq, bne, sw. Reads rs: all except j, lui.
- Load-use: EX memread & ex_dst!=0 & (ex_dst==id_rs & reads rs | ex_dst==id_rt & reads rt) -> id_stall=1, bubble enters EX.
- Forwarding (per operand, on registered ex_rs/ex_rt): MEM regwrite & mem_dst!=0 & match -> 10; else WB match -> 01; else 00. MEM has priority.
- Jump in ID (not stalled) -> if_flush=1. branch_taken with EX branch -> if_flush=1 and bubble into EX, overriding load-use.
- Mem wait: MEM memread|memwrite & !mem_ready -> freeze ID/EX/MEM registers, bubble into WB, id_stall=1, if_flush=0, branch_taken ignored.
- Priority: mem wait > branch flush > load-use > normal advance.
- stall_cnt +1 per cycle id_stall=1; flush_cnt +1 per cycle if_flush=1; both saturate at all-ones.

## Timing
- Decode, hazard, forward, flush, stall outputs are combinational from current state/inputs; stage registers update on the rising edge.
- Control word reaches EX 1 cycle after ID, MEM 2, WB 3 (no stalls).
- Load-use costs exactly 1 bubble; a taken branch costs 2 (IF and ID killed).
- Reset (any time, async): all stage registers to bubble, dst 0, counters 0; outputs id_stall=0, if_flush=0, fwd 00, illegal per current ID inputs.
- mem_ready held low N cycles -> exactly N freeze cycles, N WB bubbles.

## Structure
- Package pipe_ctrl_pkg: opcode constants, control-word bit indices, imm_op encodings, fwd select encodings, CW_W=13.
- Sub-module pipe_ctrl_decode: combinational opcode -> control word, reads-rs/reads-rt, illegal.

## Test plan
- lw $2 then add $3,$2,$4 -> id_stall=1 one cycle, ex_cw=0 next cycle, then fwd_a=01 for add in EX.
- add $5 then sub using $5 back-to-back -> fwd_a=10, no stall; with $0 as dst -> fwd_a=00.
- beq in EX with branch_taken=1 -> if_flush=1, ex_cw=0 next cycle, flush_cnt=1.
- sw in MEM, mem_ready low 3 cycles -> mem_cw stable 3 cycles, wb_cw=0 3 cycles, stall_cnt=3.
- id_op=0x3F, id_valid=1 -> illegal=1, bubble enters EX; ori (0x0D) -> imm_op=011, alusrc=1, regwrite=1, ex_dst=rt.
- rst_n low mid-stream with a lw in MEM -> all cw/dst zero immediately, counters zero; preset stall_cnt at all-ones stays saturated.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipelined MIPS control unit.
//   - opcode constants for the supported instruction set
//   - bit positions inside the 13-bit control word
//   - immediate-operation and forwarding-select encodings
//   - helper that builds the control word of an ALU-immediate instruction
package pipe_ctrl_pkg;

  localparam int CW_W = 13;

  // Opcodes (6-bit MIPS primary opcode field)
  localparam logic [5:0] OPC_R    = 6'h00;
  localparam logic [5:0] OPC_J    = 6'h02;
  localparam logic [5:0] OPC_BEQ  = 6'h04;
  localparam logic [5:0] OPC_BNE  = 6'h05;
  localparam logic [5:0] OPC_ADDI = 6'h08;
  localparam logic [5:0] OPC_SLTI = 6'h0A;
  localparam logic [5:0] OPC_ANDI = 6'h0C;
  localparam logic [5:0] OPC_ORI  = 6'h0D;
  localparam logic [5:0] OPC_LUI  = 6'h0F;
  localparam logic [5:0] OPC_LW   = 6'h23;
  localparam logic [5:0] OPC_SW   = 6'h2B;

  // Control word bit positions, MSB first
  localparam int CW_REGDST   = 12;
  localparam int CW_ALUSRC   = 11;
  localparam int CW_ALU_R    = 10;
  localparam int CW_BRANCH   = 9;
  localparam int CW_BNE      = 8;
  localparam int CW_JUMP     = 7;
  localparam int CW_IMM_HI   = 6;
  localparam int CW_IMM_LO   = 4;
  localparam int CW_MEMREAD  = 3;
  localparam int CW_MEMWRITE = 2;
  localparam int CW_MEMTOREG = 1;
  localparam int CW_REGWRITE = 0;

  typedef enum logic [2:0] {
    IMM_NONE = 3'b000,
    IMM_ADDI = 3'b001,
    IMM_ANDI = 3'b010,
    IMM_ORI  = 3'b011,
    IMM_SLTI = 3'b100,
    IMM_LUI  = 3'b101
  } imm_op_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  localparam logic [CW_W-1:0] CW_BUBBLE = '0;

  // ALU-immediate instructions share alusrc/regwrite and differ only in imm_op
  function automatic logic [CW_W-1:0] cw_imm_alu(input imm_op_e imm);
    logic [CW_W-1:0] cw;
    cw = '0;
    cw[CW_ALUSRC]              = 1'b1;
    cw[CW_IMM_HI:CW_IMM_LO]    = imm;
    cw[CW_REGWRITE]            = 1'b1;
    return cw;
  endfunction

endpackage

// File: rtl/pipe_ctrl_decode.sv
// pipe_ctrl_decode: combinational ID-stage opcode decoder.
//   valid     in   IF/ID holds a real instruction
//   op        in   opcode
//   cw        out  13-bit control word (all-zero bubble if invalid/unknown)
//   reads_rs  out  instruction uses rs as a source operand
//   reads_rt  out  instruction uses rt as a source operand
//   illegal   out  valid instruction with an unrecognised opcode
module pipe_ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic            valid,
  input  logic [OP_W-1:0] op,
  output logic [CW_W-1:0] cw,
  output logic            reads_rs,
  output logic            reads_rt,
  output logic            illegal
);

  logic known;

  always_comb begin
    cw       = CW_BUBBLE;
    known    = 1'b1;
    reads_rs = 1'b1;
    reads_rt = 1'b0;
    case (op)
      OP_W'(OPC_R): begin
        cw[CW_REGDST]   = 1'b1;
        cw[CW_ALU_R]    = 1'b1;
        cw[CW_REGWRITE] = 1'b1;
        reads_rt        = 1'b1;
      end
      OP_W'(OPC_J): begin
        cw[CW_JUMP] = 1'b1;
        reads_rs    = 1'b0;
      end
      OP_W'(OPC_BEQ): begin
        cw[CW_BRANCH] = 1'b1;
        reads_rt      = 1'b1;
      end
      OP_W'(OPC_BNE): begin
        cw[CW_BRANCH] = 1'b1;
        cw[CW_BNE]    = 1'b1;
        reads_rt      = 1'b1;
      end
      OP_W'(OPC_ADDI): cw = cw_imm_alu(IMM_ADDI);
      OP_W'(OPC_SLTI): cw = cw_imm_alu(IMM_SLTI);
      OP_W'(OPC_ANDI): cw = cw_imm_alu(IMM_ANDI);
      OP_W'(OPC_ORI):  cw = cw_imm_alu(IMM_ORI);
      OP_W'(OPC_LUI): begin
        cw       = cw_imm_alu(IMM_LUI);
        reads_rs = 1'b0;
      end
      OP_W'(OPC_LW): begin
        cw[CW_ALUSRC]   = 1'b1;
        cw[CW_MEMREAD]  = 1'b1;
        cw[CW_MEMTOREG] = 1'b1;
        cw[CW_REGWRITE] = 1'b1;
      end
      OP_W'(OPC_SW): begin
        cw[CW_ALUSRC]   = 1'b1;
        cw[CW_MEMWRITE] = 1'b1;
        reads_rt        = 1'b1;
      end
      default: known = 1'b0;
    endcase

    illegal = valid & ~known;

    // Bubbles read nothing, so they can never trigger a hazard or forward
    if (!valid || !known) begin
      cw       = CW_BUBBLE;
      reads_rs = 1'b0;
      reads_rt = 1'b0;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipelined control unit for the 5-stage MIPS core.
//   clk, rst_n                  clock / asynchronous active-low reset
//   id_valid, id_op             ID instruction presence and opcode
//   id_rs, id_rt, id_rd         ID register fields
//   branch_taken                EX branch compare result
//   mem_ready                   data memory completes the access this cycle
//   id_stall, if_flush          PC/IF-ID hold, IF/ID kill
//   ex_cw, mem_cw, wb_cw        control word per stage
//   ex_dst, mem_dst, wb_dst     destination register per stage (0 = none)
//   fwd_a, fwd_b                EX operand source selects
//   illegal                     ID holds a valid unknown opcode
//   stall_cnt, flush_cnt        saturating performance counters
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int OP_W  = 6,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [OP_W-1:0]  id_op,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             id_stall,
  output logic             if_flush,
  output logic [CW_W-1:0]  ex_cw,
  output logic [CW_W-1:0]  mem_cw,
  output logic [CW_W-1:0]  wb_cw,
  output logic [RA_W-1:0]  ex_dst,
  output logic [RA_W-1:0]  mem_dst,
  output logic [RA_W-1:0]  wb_dst,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             illegal,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [CW_W-1:0] dec_cw;
  logic            dec_reads_rs;
  logic            dec_reads_rt;
  logic [RA_W-1:0] id_dst;
  logic [RA_W-1:0] id_src_a;
  logic [RA_W-1:0] id_src_b;

  // Source registers of the EX instruction; zero when the operand is unused
  logic [RA_W-1:0] ex_rs_reg;
  logic [RA_W-1:0] ex_rt_reg;

  logic mem_wait;
  logic br_flush;
  logic load_use;
  logic mem_fwd_ok;
  logic wb_fwd_ok;

  pipe_ctrl_decode #(
    .OP_W (OP_W)
  ) u_decode (
    .valid    (id_valid),
    .op       (id_op),
    .cw       (dec_cw),
    .reads_rs (dec_reads_rs),
    .reads_rt (dec_reads_rt),
    .illegal  (illegal)
  );

  assign id_dst   = dec_cw[CW_REGWRITE] ? (dec_cw[CW_REGDST] ? id_rd : id_rt) : '0;
  assign id_src_a = dec_reads_rs ? id_rs : '0;
  assign id_src_b = dec_reads_rt ? id_rt : '0;

  // Hazard detection
  assign mem_wait = (mem_cw[CW_MEMREAD] | mem_cw[CW_MEMWRITE]) & ~mem_ready;
  assign br_flush = ~mem_wait & branch_taken & ex_cw[CW_BRANCH];
  assign load_use = ex_cw[CW_MEMREAD] && (ex_dst != '0) &&
                    ((dec_reads_rs && ex_dst == id_rs) ||
                     (dec_reads_rt && ex_dst == id_rt));

  assign id_stall = mem_wait | (~br_flush & load_use);
  // Gated by rst_n so a jump sitting in ID during reset does not flush
  assign if_flush = rst_n & ~mem_wait &
                    (br_flush | (~load_use & dec_cw[CW_JUMP]));

  // Forwarding: the younger result in MEM wins over WB
  assign mem_fwd_ok = mem_cw[CW_REGWRITE] && (mem_dst != '0);
  assign wb_fwd_ok  = wb_cw[CW_REGWRITE]  && (wb_dst  != '0);

  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (wb_fwd_ok  && wb_dst  == ex_rs_reg) fwd_a = FWD_WB;
    if (mem_fwd_ok && mem_dst == ex_rs_reg) fwd_a = FWD_MEM;
    if (wb_fwd_ok  && wb_dst  == ex_rt_reg) fwd_b = FWD_WB;
    if (mem_fwd_ok && mem_dst == ex_rt_reg) fwd_b = FWD_MEM;
  end

  // Stage registers and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_cw     <= CW_BUBBLE;
      mem_cw    <= CW_BUBBLE;
      wb_cw     <= CW_BUBBLE;
      ex_dst    <= '0;
      mem_dst   <= '0;
      wb_dst    <= '0;
      ex_rs_reg <= '0;
      ex_rt_reg <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (mem_wait) begin
        // ID/EX and EX/MEM hold; the freeze shows up as WB bubbles
        wb_cw  <= CW_BUBBLE;
        wb_dst <= '0;
      end else begin
        wb_cw   <= mem_cw;
        wb_dst  <= mem_dst;
        mem_cw  <= ex_cw;
        mem_dst <= ex_dst;
        if (br_flush || load_use) begin
          ex_cw     <= CW_BUBBLE;
          ex_dst    <= '0;
          ex_rs_reg <= '0;
          ex_rt_reg <= '0;
        end else begin
          ex_cw     <= dec_cw;
          ex_dst    <= id_dst;
          ex_rs_reg <= id_src_a;
          ex_rt_reg <= id_src_b;
        end
      end

      if (id_stall && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (if_flush && flush_cnt != {CNT_W{1'b1}})
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
